// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, defaults and helpers for the UART transmit arbiter
//
// Purpose : arbiter state encoding, default parameter values and the byte-lane
//           slicing helper used to pick one requester's byte from the packed bus.
// Ports   : none (package).
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_WAIT_DONE = 2'd2
   } arb_state_t;

   localparam int NREQ_DEF    = 4;
   localparam int IDW_DEF     = 3;
   localparam int TIMEOUT_DEF = 65535;
   localparam int TW_DEF      = 16;

   // Byte idx of a packed byte bus; the bus is zero-extended to 8 lanes by the caller.
   function automatic logic [7:0] byte_lane(input logic [63:0] i_bus, input int i_idx);
      return i_bus[i_idx*8 +: 8];
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin selector with grant lock
//
// Purpose : picks the next requester. A valid lock keeps the last winner while it
//           still requests; otherwise the search starts just after the last winner.
// Ports   : i_req        - request vector
//           i_last       - index of last winner
//           i_lock_valid - last winner holds the lock
//           o_winner     - chosen index (equals i_last when nothing requests)
//           o_any        - at least one request present
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = IDW_DEF
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_last,
   input  logic            i_lock_valid,
   output logic [IDW-1:0]  o_winner,
   output logic            o_any
);

   logic w_lock_hit;
   int   w_best;
   int   w_dist;

   always_comb begin
      o_winner   = i_last;
      w_lock_hit = 1'b0;
      w_best     = NREQ;
      w_dist     = 0;
      o_any      = |i_req;
      // Rotating distance from the last winner: last+1 is 0, last itself is NREQ-1.
      for (int i = 0; i < NREQ; i++) begin
         if (i_req[i]) begin
            w_dist = (i + NREQ - int'(i_last) - 1) % NREQ;
            if (w_dist < w_best) begin
               w_best   = w_dist;
               o_winner = IDW'(i);
            end
            if (i == int'(i_last)) begin
               w_lock_hit = i_lock_valid;
            end
         end
      end
      if (w_lock_hit) begin
         o_winner = i_last;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART byte transmitter
//
// Purpose : grants one requester at a time, loads its byte into the transmitter,
//           holds tx_data for the whole frame and waits for the frame to finish.
//           Optional wait-state timeout under macro UART_ARB_TIMEOUT_EN.
// Ports   : i_sysclk, i_rst_n     - clock, asynchronous active-low reset
//           i_req, i_req_lock     - per-requester request level and lock request
//           i_req_data            - packed bytes, requester i at [8i+7:8i]
//           o_ack                 - one-cycle pulse, byte latched
//           o_gnt_id              - current/last granted requester
//           o_busy                - high from load until frame complete
//           o_tx_data, o_tx_start - to transmitter
//           i_tx_status           - from transmitter, 1 = ready or stop bit
//           o_err, o_err_id       - timeout pulse and offending requester
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int IDW     = IDW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW      = TW_DEF
) (
   input  logic              i_sysclk,
   input  logic              i_rst_n,
   input  logic [NREQ-1:0]   i_req,
   input  logic [NREQ-1:0]   i_req_lock,
   input  logic [8*NREQ-1:0] i_req_data,
   output logic [NREQ-1:0]   o_ack,
   output logic [IDW-1:0]    o_gnt_id,
   output logic              o_busy,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_start,
   input  logic              i_tx_status,
   output logic              o_err,
   output logic [IDW-1:0]    o_err_id
);

   if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT < 1 || TIMEOUT > (1 << TW) - 1)
   begin : g_param_check
      $error("uart_tx_arbiter: parameter combination out of range");
   end

   arb_state_t       r_state, w_state_nxt;
   logic [NREQ-1:0]  r_ack, w_ack_nxt;
   logic [IDW-1:0]   r_gnt_id, w_gnt_nxt;
   logic             r_busy, w_busy_nxt;
   logic [7:0]       r_tx_data, w_tx_data_nxt;
   logic             r_tx_start, w_tx_start_nxt;
   logic             r_lock, w_lock_nxt;
   logic             w_load;
   logic [IDW-1:0]   w_winner;
   logic             w_any;
   logic [NREQ-1:0]  w_sel;
   logic [63:0]      w_data_ext;

`ifdef UART_ARB_TIMEOUT_EN
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0]    r_cnt;
   logic             r_err, w_err_nxt;
   logic [IDW-1:0]   r_err_id, w_err_id_nxt;
`endif

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .i_req        (i_req),
      .i_last       (r_gnt_id),
      .i_lock_valid (r_lock),
      .o_winner     (w_winner),
      .o_any        (w_any)
   );

   always_comb begin
      w_data_ext                = '0;
      w_data_ext[8*NREQ-1:0]    = i_req_data;
      w_sel                     = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_ack_nxt      = '0;
      w_gnt_nxt      = r_gnt_id;
      w_busy_nxt     = r_busy;
      w_tx_data_nxt  = r_tx_data;
      w_tx_start_nxt = r_tx_start;
      w_lock_nxt     = r_lock;
      w_load         = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      w_err_nxt      = 1'b0;
      w_err_id_nxt   = r_err_id;
`endif
      unique case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_load         = 1'b1;
               w_state_nxt    = ST_WAIT_BUSY;
               w_tx_data_nxt  = byte_lane(w_data_ext, int'(w_winner));
               w_tx_start_nxt = 1'b1;
               w_ack_nxt      = w_sel;
               w_gnt_nxt      = w_winner;
               w_busy_nxt     = 1'b1;
               // Lock is captured together with the byte it belongs to.
               w_lock_nxt     = |(i_req_lock & w_sel);
            end
         end
         ST_WAIT_BUSY: begin
            // Start stays up until the transmitter has really left ready/stop.
            if (!i_tx_status) begin
               w_tx_start_nxt = 1'b0;
               w_state_nxt    = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (i_tx_status) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
`ifdef UART_ARB_TIMEOUT_EN
      // Fires on the edge where the counter would reach TIMEOUT; the byte is dropped.
      if (r_state != ST_IDLE && r_cnt == TO_LAST) begin
         w_state_nxt    = ST_IDLE;
         w_tx_start_nxt = 1'b0;
         w_busy_nxt     = 1'b0;
         w_lock_nxt     = 1'b0;
         w_err_nxt      = 1'b1;
         w_err_id_nxt   = r_gnt_id;
      end
`endif
   end

   always_ff @(posedge i_sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_ack      <= '0;
         r_gnt_id   <= IDW'(NREQ - 1);
         r_busy     <= 1'b0;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
         r_lock     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ack      <= w_ack_nxt;
         r_gnt_id   <= w_gnt_nxt;
         r_busy     <= w_busy_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_start <= w_tx_start_nxt;
         r_lock     <= w_lock_nxt;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge i_sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_err    <= 1'b0;
         r_err_id <= '0;
      end else begin
         r_err    <= w_err_nxt;
         r_err_id <= w_err_id_nxt;
         if (w_load) begin
            r_cnt <= '0;
         end else if (r_state != ST_IDLE && r_cnt != {TW{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_err    = r_err;
   assign o_err_id = r_err_id;
`else
   assign o_err    = 1'b0;
   assign o_err_id = '0;
`endif

   assign o_ack      = r_ack;
   assign o_gnt_id   = r_gnt_id;
   assign o_busy     = r_busy;
   assign o_tx_data  = r_tx_data;
   assign o_tx_start = r_tx_start;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a serial transmitter model
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int BAUD = 8;
`else
   localparam int BAUD = 16;
`endif

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  req_lock = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  ack;
   logic [2:0]  gnt_id;
   logic        busy;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_status = 1'b1;
   logic        err;
   logic [2:0]  err_id;

   int n_cmp = 0;
   int n_err = 0;

   exp_t       exp_q[$];
   logic [7:0] byte_q[$];
   logic [7:0] rx_q[$];

   int         m_state = 0;
   int         m_cnt = 0;
   int         m_bit = 0;
   logic [7:0] m_rx = '0;
   logic       line = 1'b1;
   bit         stuck = 1'b0;
   bit         ignore_rx = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NREQ    (4),
      .IDW     (3),
      .TIMEOUT (100),
      .TW      (16)
   ) dut (
      .i_sysclk    (clk),
      .i_rst_n     (rst_n),
      .i_req       (req),
      .i_req_lock  (req_lock),
      .i_req_data  (req_data),
      .o_ack       (ack),
      .o_gnt_id    (gnt_id),
      .o_busy      (busy),
      .o_tx_data   (tx_data),
      .o_tx_start  (tx_start),
      .i_tx_status (tx_status),
      .o_err       (err),
      .o_err_id    (err_id)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Transmitter: reads tx_data live at each bit start, not reset by rst_n.
   always @(posedge clk) begin
      case (m_state)
         0: begin
            tx_status <= 1'b1;
            line      <= 1'b1;
            if (tx_start && !stuck) begin
               m_state   <= 1;
               m_cnt     <= 0;
               tx_status <= 1'b0;
               line      <= 1'b0;
            end
         end
         1: begin
            if (m_cnt == BAUD - 1) begin
               m_state <= 2;
               m_cnt   <= 0;
               m_bit   <= 0;
               line    <= tx_data[0];
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
         2: begin
            if (m_cnt == BAUD / 2) m_rx[m_bit] <= line;
            if (m_cnt == BAUD - 1) begin
               m_cnt <= 0;
               if (m_bit == 7) begin
                  m_state   <= 3;
                  tx_status <= 1'b1;
                  line      <= 1'b1;
                  if (!ignore_rx) rx_q.push_back(m_rx);
               end else begin
                  m_bit <= m_bit + 1;
                  line  <= tx_data[m_bit + 1];
               end
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
         default: begin
            if (m_cnt == BAUD - 1) begin
               m_state <= 0;
               m_cnt   <= 0;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      endcase
   end

   // Scoreboard: grants checked on ack, serial bytes checked as they complete.
   logic [3:0] prev_ack = '0;
   logic       prev_busy = 1'b0;
   int         cyc = 0;
   int         fall_cyc = -1;
   int         last_ack_cyc = -1;
   bit         chk_gap = 1'b0;

   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] r;
      cyc++;
      if (prev_busy && !busy) fall_cyc = cyc;
      if (ack != 4'b0) begin
         check("ack_one_cycle", {28'b0, prev_ack}, 32'd0);
         if (exp_q.size() == 0) begin
            check("ack_unexpected", {28'b0, ack}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("ack_onehot", {28'b0, ack}, 32'd1 << e.id);
            check("gnt_id", {29'b0, gnt_id}, e.id);
            check("tx_data_load", {24'b0, tx_data}, {24'b0, e.data});
            byte_q.push_back(e.data);
            if (chk_gap && fall_cyc > last_ack_cyc) check("ack_after_stop", cyc - fall_cyc, 1);
         end
         last_ack_cyc = cyc;
      end
      if (rx_q.size() > 0) begin
         r = rx_q.pop_front();
         if (byte_q.size() == 0) check("rx_unexpected", byte_q.size(), 1);
         else check("rx_byte", {24'b0, r}, {24'b0, byte_q.pop_front()});
      end
      prev_ack  = ack;
      prev_busy = busy;
   end

   task automatic set_lane(input int id, input logic [7:0] d);
      req_data[id*8 +: 8] = d;
   endtask

   task automatic push(input int id, input logic [7:0] d);
      exp_t e;
      e.id   = id;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(input int max, output int c);
      bit seen = 1'b0;
      c = 0;
      while (!seen && c < max) begin
         @(negedge clk);
         c++;
         if (ack != 4'b0) seen = 1'b1;
      end
      check("ack_seen", seen, 1);
   endtask

   task automatic wait_idle(input int max);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (busy && c < max);
      check("busy_release", busy, 0);
   endtask

   task automatic wait_status_low(input int max);
      int c = 0;
      while (tx_status && c < max) begin
         @(negedge clk);
         c++;
      end
      check("tx_status_low", tx_status, 0);
   endtask

   task automatic pulse_reset(input int n);
      rst_n = 1'b0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int c;
      repeat (3) @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_gnt_id", gnt_id, 3);
      check("rst_busy", busy, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_err", err, 0);
      check("rst_err_id", err_id, 0);
      rst_n = 1'b1;

      // single request
      @(negedge clk);
      set_lane(2, 8'h55);
      req[2] = 1'b1;
      push(2, 8'h55);
      wait_ack(10, c);
      check("t1_latency", c, 1);
      req[2] = 1'b0;
      check("t1_start", tx_start, 1);
      check("t1_busy", busy, 1);
      wait_status_low(20);
      check("t1_start_hold", tx_start, 1);
      @(negedge clk);
      check("t1_start_drop", tx_start, 0);
      wait_idle(400);
      check("t1_data_hold", tx_data, 8'h55);
      repeat (3) @(negedge clk);
      check("t1_bytes_done", byte_q.size(), 0);

      // round robin among 0,1,3 from reset
      pulse_reset(3);
      set_lane(0, 8'hA0);
      set_lane(1, 8'hA1);
      set_lane(3, 8'hA3);
      req = 4'b1011;
      push(0, 8'hA0); push(1, 8'hA1); push(3, 8'hA3); push(0, 8'hA0); push(1, 8'hA1);
      wait_ack(10, c);
      @(posedge clk);
      chk_gap = 1'b1;
      for (int k = 0; k < 4; k++) wait_ack(400, c);
      req = 4'b0000;
      chk_gap = 1'b0;
      wait_idle(400);
      check("t2_queue_empty", exp_q.size(), 0);

      // locked three-byte message from requester 1 while 0 waits
      set_lane(1, 8'hB1);
      req_lock[1] = 1'b1;
      req[1] = 1'b1;
      push(1, 8'hB1); push(1, 8'hB2); push(1, 8'hB3); push(0, 8'hC0);
      wait_ack(400, c);
      set_lane(1, 8'hB2);
      set_lane(0, 8'hC0);
      req[0] = 1'b1;
      @(posedge clk);
      chk_gap = 1'b1;
      wait_ack(400, c);
      set_lane(1, 8'hB3);
      req_lock[1] = 1'b0;
      wait_ack(400, c);
      req[1] = 1'b0;
      wait_ack(400, c);
      req[0] = 1'b0;
      chk_gap = 1'b0;
      wait_idle(400);

      // asynchronous reset during WAIT_DONE
      set_lane(3, 8'h3C);
      req[3] = 1'b1;
      push(3, 8'h3C);
      wait_ack(400, c);
      req[3] = 1'b0;
      wait_status_low(20);
      repeat (20) @(negedge clk);
      ignore_rx = 1'b1;
      byte_q.delete();
      #2 rst_n = 1'b0;
      #1;
      check("t4_async_busy", busy, 0);
      check("t4_async_start", tx_start, 0);
      check("t4_async_data", tx_data, 0);
      check("t4_async_gnt", gnt_id, 3);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      c = 0;
      while (m_state != 0 && c < 400) begin
         @(negedge clk);
         c++;
      end
      check("t4_tx_finished", m_state, 0);
      ignore_rx = 1'b0;
      set_lane(0, 8'hD0);
      set_lane(1, 8'hD1);
      req = 4'b0011;
      push(0, 8'hD0); push(1, 8'hD1);
      wait_ack(10, c);
      check("t4_first_latency", c, 1);
      req[0] = 1'b0;
      wait_ack(400, c);
      req = 4'b0000;
      wait_idle(400);

      // requester 2 pulses only while not idle
      set_lane(0, 8'hE0);
      req[0] = 1'b1;
      push(0, 8'hE0);
      wait_ack(400, c);
      req[0] = 1'b0;
      wait_status_low(20);
      repeat (5) @(negedge clk);
      set_lane(2, 8'hEE);
      req[2] = 1'b1;
      repeat (10) @(negedge clk);
      req[2] = 1'b0;
      set_lane(1, 8'hE1);
      req[1] = 1'b1;
      push(1, 8'hE1);
      wait_ack(400, c);
      req[1] = 1'b0;
      wait_idle(400);
      repeat (5) @(negedge clk);
      check("t5_queue_empty", exp_q.size(), 0);

`ifdef UART_ARB_TIMEOUT_EN
      // transmitter never leaves ready
      repeat (BAUD + 2) @(negedge clk);
      stuck = 1'b1;
      set_lane(3, 8'h77);
      req[3] = 1'b1;
      push(3, 8'h77);
      wait_ack(400, c);
      req[3] = 1'b0;
      c = 0;
      while (tx_start && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("t6_timeout_cycle", c, 100);
      check("t6_err", err, 1);
      check("t6_err_id", err_id, 3);
      check("t6_busy", busy, 0);
      @(negedge clk);
      check("t6_err_pulse", err, 0);
      byte_q.delete();
      stuck = 1'b0;
`else
      check("err_tied", err, 0);
      check("err_id_tied", err_id, 0);
`endif

      repeat (5) @(negedge clk);
      check("end_exp_empty", exp_q.size(), 0);
      check("end_bytes_empty", byte_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
